// File: rtl/nzcv_pkg.sv
// Shared opcode, condition-code and flag-index definitions for the NZCV status unit.
package nzcv_pkg;

  typedef logic [3:0] nzcv_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/nzcv_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against {N,Z,C,V}.
module nzcv_cond_eval
  import nzcv_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/nzcv_flag_unit.sv
// Registered NZCV flag register with ALU-driven update, direct write, condition
// evaluation and a LIFO save/restore stack for exception entry/return.
module nzcv_flag_unit
  import nzcv_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter int         DEPTH       = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] op_result,
  input  logic             wr_en,
  input  logic [3:0]       wr_flags,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  output logic [3:0]       flags,
  output logic             cond_pass,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // CMP ignores op_result and flags its own in1-in2; MUL leaves V as it was.
  function automatic nzcv_t alu_flags(input logic [3:0]       op,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] r,
                                      input logic             v_prev);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] res;
    logic        [WIDTH:0]   sum;
    nzcv_t                   f;
    sa  = $signed(a);
    sb  = $signed(b);
    res = (op == OP_CMP) ? $signed(a - b) : $signed(r);
    sum = {1'b0, a} + {1'b0, b};
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_Z] = (res == '0);
    case (op)
      OP_ADD: begin
        f[FLAG_C] = sum[WIDTH];
        f[FLAG_V] = (sa[WIDTH-1] == sb[WIDTH-1]) && (res[WIDTH-1] != sa[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        f[FLAG_C] = (a >= b);
        f[FLAG_V] = (sa[WIDTH-1] != sb[WIDTH-1]) && (res[WIDTH-1] != sa[WIDTH-1]);
      end
      OP_MUL: begin
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = v_prev;
      end
      default: begin
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = 1'b0;
      end
    endcase
    return f;
  endfunction

  nzcv_t            flags_q, flags_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec;
  logic             err_q, err_d;
  logic             push_ok, pop_ok, alu_upd;
  logic             full, empty;
  nzcv_t            stack_top;
  nzcv_t            stack_mem [0:(1<<IDX_W)-1];

  assign full      = (ptr_q == PTR_W'(DEPTH));
  assign empty     = (ptr_q == '0);
  assign ptr_dec   = ptr_q - PTR_W'(1);
  assign stack_top = stack_mem[ptr_dec[IDX_W-1:0]];

  always_comb begin
    push_ok = push && !pop && !full;
    pop_ok  = pop && !push && !empty;
    err_d   = (push && pop) || (push && !pop && full) || (pop && !push && empty);
    alu_upd = in_valid && s_bit && (opcode != OP_NOP);

    ptr_d = ptr_q;
    if (push_ok)     ptr_d = ptr_q + PTR_W'(1);
    else if (pop_ok) ptr_d = ptr_dec;

    flags_d = flags_q;
    if (wr_en)        flags_d = wr_flags;
    else if (pop_ok)  flags_d = stack_top;
    else if (alu_upd) flags_d = alu_flags(opcode, in1, in2, op_result, flags_q[FLAG_V]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Stack storage holds data only; the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[ptr_q[IDX_W-1:0]] <= flags_q;
  end

  nzcv_cond_eval u_cond (
    .flags (flags_q),
    .cond  (cond),
    .pass  (cond_pass)
  );

  assign flags       = flags_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed and randomized bench for nzcv_flag_unit against an arithmetic reference model.
module tb_nzcv_flag_unit;
  import nzcv_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk, rst_n, in_valid, s_bit, wr_en, push, pop;
  logic [3:0]    opcode, wr_flags, cond, flags;
  logic [W-1:0]  in1, in2, op_result;
  logic          cond_pass, stack_full, stack_empty, stack_err;

  nzcv_flag_unit #(.WIDTH(W), .DEPTH(D), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .s_bit(s_bit),
    .in1(in1), .in2(in2), .op_result(op_result), .wr_en(wr_en), .wr_flags(wr_flags),
    .push(push), .pop(pop), .cond(cond), .flags(flags), .cond_pass(cond_pass),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] mflags;
  logic       merr;
  logic [3:0] mstk[$];
  logic [3:0] cc_tab [7] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'hA, 4'hC, 4'hF};
  logic       ce_tab [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags from the arithmetic meaning of each op: true signed range for V, true unsigned carry/borrow for C.
  function automatic logic [3:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] r,
                                           input logic vprev);
    longint     sa, sb, t, hi, lo;
    logic [31:0] res;
    logic        n, z, c, v;
    hi  = 64'sd2147483647;
    lo  = -hi - 1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = (op == OP_CMP) ? a - b : r;
    n = res[31];
    z = (res == 32'd0);
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        t = sa + sb;
        v = (t > hi) || (t < lo);
      end
      OP_SUB, OP_CMP: begin
        c = (a >= b);
        t = sa - sb;
        v = (t > hi) || (t < lo);
      end
      OP_MUL: v = vprev;
      default: ;
    endcase
    return {n, z, c, v};
  endfunction

  function automatic logic cond_model(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;          4'h1: return !z;
      4'h2: return c;          4'h3: return !c;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return c && !z;    4'h9: return !c || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    in_valid = 0; s_bit = 0; opcode = OP_NOP; in1 = '0; in2 = '0; op_result = '0;
    wr_en = 0; wr_flags = 4'h0; push = 0; pop = 0;
  endtask

  // Advance the model with the inputs as driven, clock the DUT, then compare.
  task automatic tick(input string tag);
    logic [3:0] nf;
    logic       perr;
    int         sz;
    sz   = mstk.size();
    perr = (push && pop) || (push && !pop && sz == D) || (pop && !push && sz == 0);
    nf   = mflags;
    if (in_valid && s_bit && opcode != OP_NOP) nf = alu_model(opcode, in1, in2, op_result, mflags[0]);
    if (pop && !push && sz > 0) nf = mstk[sz-1];
    if (wr_en) nf = wr_flags;
    if (push && !pop && sz < D) mstk.push_back(mflags);
    else if (pop && !push && sz > 0) void'(mstk.pop_back());
    mflags = nf;
    merr   = perr;
    @(posedge clk); #1;
    chk({tag, ".flags"}, 32'(flags), 32'(mflags));
    chk({tag, ".err"},   32'(stack_err), 32'(merr));
    chk({tag, ".full"},  32'(stack_full), 32'(mstk.size() == D));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(mstk.size() == 0));
    chk({tag, ".cond"},  32'(cond_pass), 32'(cond_model(mflags, cond)));
  endtask

  initial begin
    int r;
    logic [3:0] ops [7];
    idle();
    cond   = 4'h0;
    rst_n  = 1'b0;
    mflags = 4'b0000;
    merr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flags", 32'(flags), 32'h0);
    chk("rst.empty", 32'(stack_empty), 32'h1);
    chk("rst.full",  32'(stack_full), 32'h0);
    chk("rst.err",   32'(stack_err), 32'h0);
    rst_n = 1'b1;

    // 1: ADD overflow then ADD carry to zero
    idle(); in_valid = 1; s_bit = 1; opcode = OP_ADD;
    in1 = 32'h7FFF_FFFF; in2 = 32'h1; op_result = 32'h8000_0000;
    tick("t1a"); chk("t1a.const", 32'(flags), 32'h9);
    in1 = 32'hFFFF_FFFF; in2 = 32'h1; op_result = 32'h0;
    tick("t1b"); chk("t1b.const", 32'(flags), 32'h6);

    // 2: CMP and SUB
    opcode = OP_CMP; in1 = 32'd3; in2 = 32'd5; op_result = 32'hDEAD_BEEF;
    tick("t2a"); chk("t2a.const", 32'(flags), 32'h8);
    in1 = 32'd5; in2 = 32'd5; op_result = 32'h1234_5678;
    tick("t2b"); chk("t2b.const", 32'(flags), 32'h6);
    opcode = OP_SUB; in1 = 32'h8000_0000; in2 = 32'h1; op_result = 32'h7FFF_FFFF;
    tick("t2c"); chk("t2c.const", 32'(flags), 32'h3);

    // 3: no-update cases and MUL keeping V
    idle(); in_valid = 1; s_bit = 0; opcode = OP_ADD; op_result = 32'h0;
    tick("t3a"); chk("t3a.const", 32'(flags), 32'h3);
    s_bit = 1; opcode = OP_NOP;
    tick("t3b"); chk("t3b.const", 32'(flags), 32'h3);
    opcode = OP_MUL; in1 = 32'd5; in2 = 32'd1; op_result = 32'd5;
    tick("t3c"); chk("t3c.const", 32'(flags), 32'h1);

    // 4: fill the stack, overflow, drain, underflow
    idle(); wr_en = 1; wr_flags = 4'h1; tick("t4w");
    for (int k = 2; k <= 4; k++) begin
      idle(); push = 1; wr_en = 1; wr_flags = 4'(k); tick("t4p");
    end
    idle(); push = 1; tick("t4p4");
    chk("t4.full", 32'(stack_full), 32'h1);
    idle(); push = 1; tick("t4ovf");
    chk("t4.ovf_err", 32'(stack_err), 32'h1);
    idle(); tick("t4idle");
    chk("t4.err_clr", 32'(stack_err), 32'h0);
    for (int k = 4; k >= 1; k--) begin
      idle(); pop = 1; tick("t4pop");
      chk("t4.pop_val", 32'(flags), 32'(k));
    end
    idle(); pop = 1; tick("t4unf");
    chk("t4.unf_err", 32'(stack_err), 32'h1);
    chk("t4.unf_flags", 32'(flags), 32'h1);

    // 5: condition codes on 0110, then wr_en beats pop
    idle(); wr_en = 1; wr_flags = 4'b0110; tick("t5w");
    idle();
    for (int i = 0; i < 7; i++) begin
      cond = cc_tab[i];
      #1;
      chk("t5.cond", 32'(cond_pass), 32'(ce_tab[i]));
    end
    push = 1; tick("t5push");
    idle(); wr_en = 1; wr_flags = 4'b1000; pop = 1; tick("t5wrpop");
    chk("t5.wr_over_pop", 32'(flags), 32'h8);

    // Randomized traffic
    ops = '{OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_NOP, 4'h5, 4'hB};
    repeat (400) begin
      idle();
      in_valid = 1'($urandom_range(0, 3) != 0);
      s_bit    = 1'($urandom_range(0, 3) != 0);
      opcode   = ops[$urandom_range(0, 6)];
      in1      = $urandom();
      in2      = $urandom();
      if ($urandom_range(0, 3) == 0) in2 = in1;
      if (opcode == OP_ADD)      op_result = in1 + in2;
      else if (opcode == OP_SUB) op_result = in1 - in2;
      else                       op_result = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom();
      wr_en    = 1'($urandom_range(0, 15) == 0);
      wr_flags = 4'($urandom());
      r = $urandom_range(0, 9);
      push = (r < 3) || (r == 6);
      pop  = (r >= 3 && r <= 6);
      cond = 4'($urandom());
      tick("rnd");
    end

    // 6: async reset after two pushes
    while (mstk.size() > 0) begin
      idle(); pop = 1; tick("t6drain");
    end
    idle(); wr_en = 1; wr_flags = 4'h5; tick("t6w");
    idle(); push = 1; tick("t6p1");
    idle(); push = 1; wr_en = 1; wr_flags = 4'hA; tick("t6p2");
    idle();
    #3 rst_n = 1'b0;
    #1;
    mstk.delete();
    mflags = 4'b0000;
    merr   = 1'b0;
    chk("t6.flags", 32'(flags), 32'h0);
    chk("t6.empty", 32'(stack_empty), 32'h1);
    chk("t6.full",  32'(stack_full), 32'h0);
    chk("t6.err",   32'(stack_err), 32'h0);
    @(posedge clk); #1;
    chk("t6.hold_flags", 32'(flags), 32'h0);
    rst_n = 1'b1;
    idle(); pop = 1; tick("t6pop_after_rst");
    chk("t6.unf_err", 32'(stack_err), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
